// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the sequential divider and its single-step datapath.
//   div_state_t       : divider FSM states (IDLE, RUN, FIX, DONE)
//   DIV_WIDTH_DEFAULT : default operand/result width in bits
//   DIV_ZERO_Q_FILL   : bit value replicated across the quotient on divide-by-zero
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // A divide-by-zero returns an all-ones quotient.
  localparam logic DIV_ZERO_Q_FILL = 1'b1;

endpackage

// File: rtl/seq_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step on unsigned magnitudes.
// Ports:
//   rem_in  [WIDTH:0] : current partial remainder
//   bit_in            : next dividend bit, shifted in at the LSB
//   dvs     [WIDTH:0] : divisor magnitude
//   rem_out [WIDTH:0] : partial remainder after the trial subtraction
//   q_bit             : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0] rem_in,
  input  logic           bit_in,
  input  logic [WIDTH:0] dvs,
  output logic [WIDTH:0] rem_out,
  output logic           q_bit
);

  // One extra bit so the shifted remainder never wraps before the compare.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] dvs_wide;

  assign shifted  = {rem_in, bit_in};
  assign dvs_wide = {1'b0, dvs};

  // Non-negative trial difference keeps the subtraction and sets the bit;
  // otherwise the shifted remainder is restored unchanged.
  assign q_bit   = (shifted >= dvs_wide);
  assign rem_out = q_bit ? (WIDTH+1)'(shifted - dvs_wide) : shifted[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring divider, one quotient bit per RUN cycle.
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands
// (quotient truncates toward zero, remainder takes the dividend's sign).
// Without it operands are unsigned; FIX is still traversed so latency is equal.
// Ports:
//   clk         : clock, rising edge
//   clr         : asynchronous active-high reset
//   start       : request a division, sampled only in IDLE
//   dividend    : numerator, captured with start
//   divisor     : denominator, captured with start
//   busy        : high in every state except IDLE
//   done        : one-cycle pulse, WIDTH+2 cycles after the accepting edge
//   quotient    : result quotient, held until the next start is accepted
//   remainder   : result remainder, held until the next start is accepted
//   div_by_zero : divisor was zero for the last operation
// -----------------------------------------------------------------------------
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  div_state_t state_reg, state_next;

  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH:0]   rem_reg;        // partial remainder
  logic [WIDTH:0]   dvs_reg;        // divisor magnitude
  logic [WIDTH-1:0] dvd_reg;        // dividend bits out at MSB, quotient bits in at LSB
  logic [WIDTH-1:0] dvd_raw_reg;    // untouched dividend for the divide-by-zero result
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             zero_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             dbz_reg;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH:0]   dvd_ext;
  logic [WIDTH:0]   dvs_ext;
  logic [WIDTH:0]   dvd_mag;
  logic [WIDTH:0]   dvs_mag;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign dvd_neg = dividend[WIDTH-1];
  assign dvs_neg = divisor[WIDTH-1];
`else
  assign dvd_neg = 1'b0;
  assign dvs_neg = 1'b0;
`endif

  // Magnitudes use WIDTH+1 bits so negating the most-negative value is exact.
  // Prepending the sign flag gives sign extension for negatives, zero
  // extension otherwise.
  assign dvd_ext = {dvd_neg, dividend};
  assign dvs_ext = {dvs_neg, divisor};
  assign dvd_mag = dvd_neg ? -dvd_ext : dvd_ext;
  assign dvs_mag = dvs_neg ? -dvs_ext : dvs_ext;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_reg),
    .bit_in  (dvd_reg[WIDTH-1]),
    .dvs     (dvs_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and status outputs
  // RUN holds for WIDTH iteration cycles plus one cycle that sees the terminal
  // count, which puts done WIDTH+2 cycles after the accepting edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt_reg == LAST_CNT) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_reg       <= '0;
      rem_reg       <= '0;
      dvs_reg       <= '0;
      dvd_reg       <= '0;
      dvd_raw_reg   <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      zero_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            cnt_reg     <= '0;
            rem_reg     <= '0;
            dvs_reg     <= dvs_mag;
            // Top magnitude bit is always zero for a WIDTH-bit operand.
            dvd_reg     <= WIDTH'(dvd_mag);
            dvd_raw_reg <= dividend;
            neg_q_reg   <= dvd_neg ^ dvs_neg;
            neg_r_reg   <= dvd_neg;
            zero_reg    <= (divisor == '0);
          end
        end
        RUN: begin
          if (cnt_reg != LAST_CNT) begin
            rem_reg <= step_rem;
            dvd_reg <= {dvd_reg[WIDTH-2:0], step_q};
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        FIX: begin
          dbz_reg <= zero_reg;
          if (zero_reg) begin
            quotient_reg  <= {WIDTH{DIV_ZERO_Q_FILL}};
            remainder_reg <= dvd_raw_reg;
          end else begin
            // Most-negative / -1 wraps back to most-negative here by design.
            quotient_reg  <= neg_q_reg ? -dvd_reg : dvd_reg;
            remainder_reg <= neg_r_reg ? -WIDTH'(rem_reg) : WIDTH'(rem_reg);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (WIDTH=32): a vector table, hand-written
// multi-cycle sequences (start in DONE, start during RUN, clr mid-operation)
// and randomized operations against an arithmetic reference model.
// Follows SEQ_DIVIDER_SIGNED_EN for signed vs. unsigned expectations.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: plain language-level division.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    longint sa;
    longint sb;
    z = (b == '0);
    if (z) begin
      q = '1;
      r = a;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
`else
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
`endif
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endfunction

  // Caller positions itself (normally at a falling edge) before calling.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Cycles after the accepting edge until done; stops at 100 on a hang.
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
  endtask

  task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    int lat;
    @(negedge clk);
    launch(a, b);
    wait_done(lat);
    chk({tag, "_latency"}, W'(lat), W'(LAT));
    chk({tag, "_quotient"}, quotient, q);
    chk({tag, "_remainder"}, remainder, r);
    chk({tag, "_dbz"}, W'(div_by_zero), W'(z));
    $display("op %s: %h / %h -> q=%h r=%h dbz=%0d lat=%0d", tag, a, b, quotient, remainder,
             div_by_zero, lat);
    @(posedge clk);
    #1;
    chk({tag, "_done_width"}, W'(done), W'(0));
    chk({tag, "_idle"}, W'(busy), W'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ndone;
    logic [W-1:0] qd, rd, eq, er;
    logic ez;
    logic [W-1:0] ra, rb;

    vecs.push_back('{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          z: 1'b0});
    vecs.push_back('{a: 32'h12345678,   b: 32'd0,          q: 32'hFFFFFFFF,   r: 32'h12345678,   z: 1'b1});
    vecs.push_back('{a: 32'd9,          b: 32'd3,          q: 32'd3,          r: 32'd0,          z: 1'b0});
    vecs.push_back('{a: 32'hFFFFFFFF,   b: 32'd1,          q: 32'hFFFFFFFF,   r: 32'd0,          z: 1'b0});
    vecs.push_back('{a: 32'd5,          b: 32'd10,         q: 32'd0,          r: 32'd5,          z: 1'b0});
    vecs.push_back('{a: 32'd0,          b: 32'd0,          q: 32'hFFFFFFFF,   r: 32'd0,          z: 1'b1});
    vecs.push_back('{a: 32'd1000000,    b: 32'd1000,       q: 32'd1000,       r: 32'd0,          z: 1'b0});
    vecs.push_back('{a: 32'h80000000,   b: 32'd0,          q: 32'hFFFFFFFF,   r: 32'h80000000,   z: 1'b1});
`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs.push_back('{a: 32'hFFFFFF9C,   b: 32'd7,          q: 32'hFFFFFFF2,   r: 32'hFFFFFFFE,   z: 1'b0});
    vecs.push_back('{a: 32'd100,        b: 32'hFFFFFFF9,   q: 32'hFFFFFFF2,   r: 32'd2,          z: 1'b0});
    vecs.push_back('{a: 32'hFFFFFF9C,   b: 32'hFFFFFFF9,   q: 32'd14,         r: 32'hFFFFFFFE,   z: 1'b0});
    vecs.push_back('{a: 32'h80000000,   b: 32'hFFFFFFFF,   q: 32'h80000000,   r: 32'd0,          z: 1'b0});
`else
    vecs.push_back('{a: 32'd100,        b: 32'hFFFFFFF9,   q: 32'd0,          r: 32'd100,        z: 1'b0});
    vecs.push_back('{a: 32'h80000000,   b: 32'hFFFFFFFF,   q: 32'd0,          r: 32'h80000000,   z: 1'b0});
    vecs.push_back('{a: 32'hFFFFFFFF,   b: 32'd2,          q: 32'h7FFFFFFF,   r: 32'd1,          z: 1'b0});
`endif

    // ---- reset state ----
    clr      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));
    chk("reset_quotient", quotient, '0);
    chk("reset_remainder", remainder, '0);
    chk("reset_dbz", W'(div_by_zero), W'(0));
    @(negedge clk);
    clr = 1'b0;

    // ---- table vectors ----
    foreach (vecs[i]) begin
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
    end

    // ---- start held high during DONE is not accepted; results then hold ----
    @(negedge clk);
    launch(32'd100, 32'd7);
    wait_done(lat);
    chk("donestart_latency", W'(lat), W'(LAT));
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("donestart_busy", W'(busy), W'(0));
    repeat (4) @(posedge clk);
    #1;
    chk("donestart_still_idle", W'(busy), W'(0));
    chk("hold_quotient", quotient, 32'd14);
    chk("hold_remainder", remainder, 32'd2);
    $display("op donestart: 100 / 7 held q=%h r=%h busy=%0d", quotient, remainder, busy);

    // ---- second start and operand changes during RUN are ignored ----
    @(negedge clk);
    launch(32'd100, 32'd7);
    ndone = 0;
    lat   = 0;
    qd    = '0;
    rd    = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat = k;
          qd  = quotient;
          rd  = remainder;
        end
      end
      if (k == 10) begin
        start    = 1'b1;
        dividend = 32'd55;
        divisor  = 32'd3;
      end
      if (k == 11) start = 1'b0;
    end
    chk("midstart_latency", W'(lat), W'(LAT));
    chk("midstart_pulses", W'(ndone), W'(1));
    chk("midstart_quotient", qd, 32'd14);
    chk("midstart_remainder", rd, 32'd2);
    $display("op midstart: 100 / 7 -> q=%h r=%h pulses=%0d lat=%0d", qd, rd, ndone, lat);

    // ---- clr mid-operation aborts; next start right after release works ----
    @(negedge clk);
    launch(32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_quotient", quotient, '0);
    chk("abort_remainder", remainder, '0);
    ndone = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort_no_done", W'(ndone), W'(0));
    @(negedge clk);
    clr = 1'b0;
    launch(32'd9, 32'd3);
    wait_done(lat);
    chk("after_abort_latency", W'(lat), W'(LAT));
    chk("after_abort_quotient", quotient, 32'd3);
    chk("after_abort_remainder", remainder, 32'd0);
    $display("op abort: clr mid-run, then 9 / 3 -> q=%h r=%h lat=%0d", quotient, remainder, lat);
    @(posedge clk);
    #1;

    // ---- randomized operations against the reference model ----
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = $urandom;
        3:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = -W'($urandom_range(1, 9));
      endcase
      if (n % 7 == 3) ra = 32'h80000000;
      ref_div(ra, rb, eq, er, ez);
      run_check($sformatf("rnd%0d", n), ra, rb, eq, er, ez);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
